// File: rtl/execute_stage.sv
// MIPS execute stage: ID/EX register, operand forwarding, ALU, RegDst mux, EX/MEM register.
// Define EXEC_OVF_TRAP_EN to suppress writeback and raise OvfM on signed add/sub overflow.
module execute_stage #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              MemWriteD,
    input  logic              ALUSrcD,
    input  logic              RegDstD,
    input  logic [3:0]        ALUControlD,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic [DATA_W-1:0] SignImmD,
    input  logic [4:0]        RsD,
    input  logic [4:0]        RtD,
    input  logic [4:0]        RdD,
    input  logic              FlushE,
    input  logic              StallE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [DATA_W-1:0] ResultW,
    output logic [4:0]        RsE,
    output logic [4:0]        RtE,
    output logic [4:0]        WriteRegE,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              RegWriteM,
    output logic              MemtoRegM,
    output logic              MemWriteM,
    output logic [DATA_W-1:0] ALUOutM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [4:0]        WriteRegM,
    output logic              OvfM
);

    typedef struct packed {
        logic              regWrite;
        logic              memtoReg;
        logic              memWrite;
        logic              aluSrc;
        logic              regDst;
        logic [3:0]        aluControl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] signImm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
    } idEx_t;

    typedef struct packed {
        logic              regWrite;
        logic              memtoReg;
        logic              memWrite;
        logic              ovf;
        logic [DATA_W-1:0] aluOut;
        logic [DATA_W-1:0] writeData;
        logic [4:0]        writeReg;
    } exMem_t;

    idEx_t  e, eNext;
    exMem_t m, mNext;

    logic [DATA_W-1:0]  srcA, srcB, rtFwd, aluResult;
    logic [SHAMT_W-1:0] shamt;
    logic               ovf;

    assign eNext = '{RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
                     ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            e <= '0;
        else if (FlushE)
            e <= '0;
        else if (!StallE)
            e <= eNext;
    end

    // Reserved select 11 falls back to the register value.
    always_comb begin
        case (ForwardAE)
            2'b01:   srcA = ResultW;
            2'b10:   srcA = ALUOutM;
            default: srcA = e.rd1;
        endcase
        case (ForwardBE)
            2'b01:   rtFwd = ResultW;
            2'b10:   rtFwd = ALUOutM;
            default: rtFwd = e.rd2;
        endcase
    end

    assign srcB  = e.aluSrc ? e.signImm : rtFwd;
    assign shamt = srcA[SHAMT_W-1:0];

    always_comb begin
        aluResult = '0;
        case (e.aluControl)
            4'b0000: aluResult = srcA + srcB;
            4'b0001: aluResult = srcA - srcB;
            4'b0010: aluResult = srcA & srcB;
            4'b0011: aluResult = srcA | srcB;
            4'b0100: aluResult = srcA ^ srcB;
            4'b0101: aluResult = ~(srcA | srcB);
            4'b0110: aluResult = {{(DATA_W-1){1'b0}},
                                  $signed(srcA) < $signed(srcB)};
            4'b0111: aluResult = srcB << shamt;
            4'b1000: aluResult = srcB >> shamt;
            4'b1001: aluResult = $signed(srcB) >>> shamt;
            default: aluResult = '0;
        endcase
    end

`ifdef EXEC_OVF_TRAP_EN
    always_comb begin
        ovf = 1'b0;
        case (e.aluControl)
            4'b0000: ovf = (srcA[DATA_W-1] == srcB[DATA_W-1]) &&
                           (aluResult[DATA_W-1] != srcA[DATA_W-1]);
            4'b0001: ovf = (srcA[DATA_W-1] != srcB[DATA_W-1]) &&
                           (aluResult[DATA_W-1] != srcA[DATA_W-1]);
            default: ovf = 1'b0;
        endcase
    end
`else
    assign ovf = 1'b0;
`endif

    assign WriteRegE = e.regDst ? e.rd : e.rt;

    always_comb begin
        mNext           = '0;
        mNext.regWrite  = e.regWrite & ~ovf;
        mNext.memtoReg  = e.memtoReg;
        mNext.memWrite  = e.memWrite;
        mNext.ovf       = ovf;
        mNext.aluOut    = aluResult;
        mNext.writeData = rtFwd;
        mNext.writeReg  = WriteRegE;
    end

    // A held E entry must not issue twice, so M takes a bubble on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m <= '0;
        else if (StallE && !FlushE)
            m <= '0;
        else
            m <= mNext;
    end

    assign RsE        = e.rs;
    assign RtE        = e.rt;
    assign RegWriteE  = e.regWrite;
    assign MemtoRegE  = e.memtoReg;
    assign RegWriteM  = m.regWrite;
    assign MemtoRegM  = m.memtoReg;
    assign MemWriteM  = m.memWrite;
    assign ALUOutM    = m.aluOut;
    assign WriteDataM = m.writeData;
    assign WriteRegM  = m.writeReg;
    assign OvfM       = m.ovf;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, ALU ops, forwarding, stall/flush, overflow.
// Build with +define+EXEC_OVF_TRAP_EN to check the overflow trap variant.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [3:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, SignImmD, ResultW;
    logic [4:0]  RsD, RtD, RdD;
    logic        FlushE, StallE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [4:0]  RsE, RtE, WriteRegE, WriteRegM;
    logic        RegWriteE, MemtoRegE;
    logic        RegWriteM, MemtoRegM, MemWriteM, OvfM;
    logic [31:0] ALUOutM, WriteDataM;

    int nAssert = 0;
    int nFail   = 0;

    execute_stage #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
        .RegDstD(RegDstD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
        .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .FlushE(FlushE), .StallE(StallE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .MemWriteM(MemWriteM), .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .OvfM(OvfM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setD(input logic rw, input logic mw, input logic src,
                        input logic dst, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
        RegWriteD = rw; MemtoRegD = 1'b0; MemWriteD = mw;
        ALUSrcD = src; RegDstD = dst; ALUControlD = op;
        RD1D = a; RD2D = b; SignImmD = imm;
        RsD = rs; RtD = rt; RdD = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        FlushE = 1'b0; StallE = 1'b0;
        ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = '0;
        setD(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
        #2;
        check("rst_ALUOutM", ALUOutM, 32'h0);
        check("rst_RegWriteM", RegWriteM, 32'h0);
        check("rst_WriteRegE", WriteRegE, 32'h0);
        #1 rst_n = 1'b1;

        // add held in E and M, then asynchronous reset mid-cycle
        setD(1, 0, 0, 1, 4'h0, 32'd5, 32'd7, 0, 5'd2, 5'd9, 5'd3);
        step();
        step();
        check("pre_rst_ALUOutM", ALUOutM, 32'd12);
        #2 rst_n = 1'b0;
        #1;
        check("async_RegWriteE", RegWriteE, 32'h0);
        check("async_RsE", RsE, 32'h0);
        check("async_WriteRegE", WriteRegE, 32'h0);
        check("async_ALUOutM", ALUOutM, 32'h0);
        check("async_RegWriteM", RegWriteM, 32'h0);
        check("async_WriteRegM", WriteRegM, 32'h0);
        #2 rst_n = 1'b1;

        // i1: add 5+7 -> r3
        setD(1, 0, 0, 1, 4'h0, 32'd5, 32'd7, 0, 5'd2, 5'd9, 5'd3);
        step();
        check("e_RsE", RsE, 32'd2);
        check("e_RtE", RtE, 32'd9);
        check("e_WriteRegE", WriteRegE, 32'd3);
        check("e_RegWriteE", RegWriteE, 32'd1);
        check("latency_M_empty", ALUOutM, 32'h0);
        // i2: add 9+7 = 0x10 -> r4
        setD(1, 0, 0, 1, 4'h0, 32'd9, 32'd7, 0, 5'd1, 5'd1, 5'd4);
        step();
        check("add_ALUOutM", ALUOutM, 32'd12);
        check("add_WriteRegM", WriteRegM, 32'd3);
        check("add_RegWriteM", RegWriteM, 32'd1);
        // i3: sub with both operands forwarded
        setD(1, 0, 0, 1, 4'h1, 32'hDEAD, 32'h55, 0, 5'd4, 5'd5, 5'd6);
        step();
        check("i2_ALUOutM", ALUOutM, 32'h10);
        ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h3;
        // i4: srav 0x80000000 by 0x24 (shamt 4)
        setD(1, 0, 0, 1, 4'h9, 32'h24, 32'h8000_0000, 0, 5'd1, 5'd2, 5'd7);
        step();
        check("fwd_sub_ALUOutM", ALUOutM, 32'h0D);
        check("fwd_WriteDataM", WriteDataM, 32'h3);
        ForwardAE = 2'b00; ForwardBE = 2'b00;
        // i5: slt -1 < 1
        setD(1, 0, 0, 1, 4'h6, 32'hFFFF_FFFF, 32'd1, 0, 5'd1, 5'd2, 5'd8);
        step();
        check("srav_ALUOutM", ALUOutM, 32'hF800_0000);
        // i6: sw, address 0x100+4, store 0xAB
        setD(0, 1, 1, 0, 4'h0, 32'h100, 32'hAB, 32'd4, 5'd1, 5'd2, 5'd0);
        step();
        check("slt_ALUOutM", ALUOutM, 32'd1);
        // i7: or 0xF0|0x0F -> r7
        setD(1, 0, 0, 1, 4'h3, 32'hF0, 32'h0F, 32'hFFFF, 5'd1, 5'd2, 5'd7);
        step();
        check("sw_ALUOutM", ALUOutM, 32'h104);
        check("sw_WriteDataM", WriteDataM, 32'hAB);
        check("sw_MemWriteM", MemWriteM, 32'd1);
        check("sw_RegWriteM", RegWriteM, 32'd0);
        // one-cycle stall with i8 (xor -> r6 via rt) waiting in D
        StallE = 1'b1;
        setD(1, 0, 0, 0, 4'h4, 32'hFF, 32'h0F, 0, 5'd1, 5'd6, 5'd9);
        step();
        check("stall_RegWriteM", RegWriteM, 32'd0);
        check("stall_ALUOutM", ALUOutM, 32'h0);
        check("stall_hold_WriteRegE", WriteRegE, 32'd7);
        check("stall_hold_RegWriteE", RegWriteE, 32'd1);
        StallE = 1'b0;
        step();
        check("post_stall_ALUOutM", ALUOutM, 32'hFF);
        check("post_stall_WriteRegM", WriteRegM, 32'd7);
        check("post_stall_RegWriteM", RegWriteM, 32'd1);
        // flush and stall together
        FlushE = 1'b1; StallE = 1'b1;
        setD(1, 0, 0, 1, 4'h0, 32'd1, 32'd1, 0, 5'd3, 5'd4, 5'd5);
        step();
        check("flush_RegWriteE", RegWriteE, 32'd0);
        check("flush_RsE", RsE, 32'd0);
        check("flush_WriteRegE", WriteRegE, 32'd0);
        check("flush_xor_ALUOutM", ALUOutM, 32'hF0);
        check("flush_xor_WriteRegM", WriteRegM, 32'd6);
        FlushE = 1'b0; StallE = 1'b0;
        // i10: add 0x7FFFFFFF + 1 -> r10
        setD(1, 0, 0, 1, 4'h0, 32'h7FFF_FFFF, 32'd1, 0, 5'd1, 5'd2, 5'd10);
        step();
        check("bubble_RegWriteM", RegWriteM, 32'd0);
        check("bubble_ALUOutM", ALUOutM, 32'h0);
        // i11: nor 0,0
        setD(1, 0, 0, 1, 4'h5, 32'h0, 32'h0, 0, 5'd1, 5'd2, 5'd11);
        step();
        check("ovf_ALUOutM", ALUOutM, 32'h8000_0000);
        check("ovf_MemWriteM", MemWriteM, 32'd0);
`ifdef EXEC_OVF_TRAP_EN
        check("ovf_OvfM", OvfM, 32'd1);
        check("ovf_RegWriteM", RegWriteM, 32'd0);
`else
        check("ovf_OvfM", OvfM, 32'd0);
        check("ovf_RegWriteM", RegWriteM, 32'd1);
`endif
        // i12: sllv 3 << (0x21 & 31), rs via reserved forward select
        setD(1, 0, 0, 1, 4'h7, 32'h21, 32'd3, 0, 5'd1, 5'd2, 5'd12);
        step();
        check("nor_ALUOutM", ALUOutM, 32'hFFFF_FFFF);
        check("nor_OvfM", OvfM, 32'd0);
        check("nor_RegWriteM", RegWriteM, 32'd1);
        ForwardAE = 2'b11; ForwardBE = 2'b11; ResultW = 32'h1F;
        // i13: reserved op 1111
        setD(1, 0, 0, 1, 4'hF, 32'd5, 32'd5, 0, 5'd1, 5'd2, 5'd13);
        step();
        check("sllv_fwd11_ALUOutM", ALUOutM, 32'd6);
        check("fwd11_WriteDataM", WriteDataM, 32'd3);
        ForwardAE = 2'b00; ForwardBE = 2'b00;
        // i14: srlv 0x80000000 >> 4, logical
        setD(1, 0, 0, 1, 4'h8, 32'h4, 32'h8000_0000, 0, 5'd1, 5'd2, 5'd14);
        step();
        check("reserved_op_ALUOutM", ALUOutM, 32'h0);
        check("reserved_op_WriteRegM", WriteRegM, 32'd13);
        step();
        check("srlv_ALUOutM", ALUOutM, 32'h0800_0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Downstream neighbour of the decode control unit in the 5-stage MIPS pipeline.
- Contains the ID/EX pipeline register, the forwarding source muxes, the ALU, the RegDst mux and the EX/MEM pipeline register.
- Consumes the D-stage control word (RegWriteD, MemtoRegD, MemWriteD, ALUControlD, ALUSrcD, RegDstD) and produces the M-stage bundle for the data-memory stage.
- Exposes E-stage fields to the hazard unit.

Parameters:
DATA_W, 32, datapath width; the only supported value is 32.
SHAMT_W, 5, shift-amount bits taken from SrcA; equals log2(DATA_W).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decode control bits
ALUControlD  in  4  ALU op code
RD1D, RD2D  in  DATA_W  register-file read data (rs, rt)
SignImmD  in  DATA_W  extended immediate, already extended upstream
RsD, RtD, RdD  in  5  register indices
FlushE  in  1  turn the E-stage entry into a bubble
StallE  in  1  hold the E-stage entry
ForwardAE, ForwardBE  in  2  forwarding select for SrcA and for the rt operand
ResultW  in  DATA_W  writeback result
RsE, RtE, WriteRegE  out  5  E-stage indices, to the hazard unit
RegWriteE, MemtoRegE  out  1  E-stage control, to the hazard unit
RegWriteM, MemtoRegM, MemWriteM  out  1  M-stage control
ALUOutM, WriteDataM  out  DATA_W  registered ALU result and store data
WriteRegM  out  5  destination register
OvfM  out  1  overflow flag (see Optional Feature)

Behaviour:
- Reset: on rst_n low, all E and M registers clear to 0 immediately; every output reads 0 while reset is held. Recovery is synchronous to the first clk edge after release.
- Latency: D inputs are captured into E at edge k; the ALU result is captured into M at edge k+1. There is no bypass from the D inputs to any output.
- E register update priority, per edge:
  - FlushE=1: all E fields become 0, which is a bubble. Flush wins over StallE.
  - Otherwise StallE=1: E holds its contents, and M loads a bubble (all control fields 0, data fields 0).
  - Otherwise: E loads the D inputs.
- Forwarding mux, per operand:
  - 00 selects the E register value (RD1E for SrcA, RD2E for the rt operand).
  - 01 selects ResultW.
  - 10 selects ALUOutM.
  - 11 is reserved and selects the E register value.
- SrcB = ALUSrcE ? SignImmE : forwarded rt operand.
- WriteDataM captures the forwarded rt operand, never SignImm.
- WriteRegE = RegDstE ? RdE : RtE.
- ALU ops, 32-bit, wrap-around arithmetic:
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor; 0101 nor.
  - 0110 slt: signed compare; result 1 if SrcA<SrcB, else 0.
  - 0111 sllv: SrcB << SrcA[4:0].
  - 1000 srlv: SrcB >> SrcA[4:0], logical.
  - 1001 srav: SrcB >>> SrcA[4:0], arithmetic.
  - 1010-1111: result 0.
- Shifts use only SrcA[SHAMT_W-1:0]; upper bits are ignored.
- Register 0: no special handling here. The writeback and register file own the r0 rule.

Optional Feature:
- Macro: EXEC_OVF_TRAP_EN.
- Defined:
  - Signed overflow on ops 0000 or 0001 forces RegWriteM=0 for that instruction.
  - The same instruction sets OvfM=1 for exactly the cycle it sits in M.
  - MemWriteM is unaffected; add/sub never assert it.
- Undefined: add/sub wrap silently, and OvfM is tied to 0.

Test Plan:
- Reset mid-operation: load an add into E, pull rst_n low between edges -> all outputs read 0 immediately, with no clk edge needed.
- add: RD1D=5, RD2D=7, RegDstD=1, RdD=3, ALUControlD=0000 -> two edges later ALUOutM=12, WriteRegM=3, RegWriteM=1.
- Forwarding: ForwardAE=10 with ALUOutM=0x10; ForwardBE=01 with ResultW=0x3; op sub -> next ALUOutM=0x0D.
- Shift/compare: srav SrcB=0x80000000, SrcA=0x24 -> 0xF8000000. slt SrcA=0xFFFFFFFF, SrcB=1 -> 1.
- sw with ALUSrcD=1: SignImmD=4, RD1D=0x100, RD2D=0xAB -> ALUOutM=0x104, WriteDataM=0xAB, MemWriteM=1, RegWriteM=0.
- Hazard controls:
  - StallE for 1 cycle -> E holds and M carries a bubble (RegWriteM=0).
  - FlushE and StallE together -> E becomes a bubble.
  - With EXEC_OVF_TRAP_EN: add 0x7FFFFFFF+1 -> OvfM=1, RegWriteM=0.
